noc_vc_input_unit: RTL and testbench

Parametrised router input port. Replaces the single-buffer, whole-packet input stage with NUM_VC virtual-channel FIFOs, credit-based upstream flow control and per-VC packet state machines. Sits between an upstream link and the switch allocator/crossbar. Each VC latches its head flit's output-port field, requests the switch, and streams flits one per grant until the tail.

---
 rtl/noc_pkg.sv | 35 +++
 rtl/noc_vc_fifo.sv | 65 ++++++
 rtl/noc_vc_input_unit.sv | 215 +++++++++++++++++++++
 tb/tb_noc_vc_input_unit.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared types and field positions for the NoC virtual-channel input unit.
// Contents:
//   FLIT_TYPE_e  - 2-bit flit type carried in the top bits of every flit
//   VC_STATE_e   - per-VC packet state machine encoding
//   TYPE_W / PORT_LSB - field widths/positions used when slicing flits
//   flit_is_head / flit_is_tail - type classification helpers
package noc_pkg;

    localparam int unsigned TYPE_W   = 2;
    localparam int unsigned PORT_LSB = 0;

    typedef enum logic [1:0] {
        FLIT_BODY   = 2'b00,
        FLIT_HEAD   = 2'b01,
        FLIT_TAIL   = 2'b10,
        FLIT_SINGLE = 2'b11
    } FLIT_TYPE_e;

    typedef enum logic [1:0] {
        VC_IDLE    = 2'd0,
        VC_ROUTING = 2'd1,
        VC_REQ     = 2'd2
    } VC_STATE_e;

    // Flit opens a packet (carries a route)
    function automatic logic flit_is_head(input FLIT_TYPE_e t);
        return (t == FLIT_HEAD) || (t == FLIT_SINGLE);
    endfunction

    // Flit closes a packet
    function automatic logic flit_is_tail(input FLIT_TYPE_e t);
        return (t == FLIT_TAIL) || (t == FLIT_SINGLE);
    endfunction

endpackage

// File: rtl/noc_vc_fifo.sv
// Single-clock FIFO holding the flits of one virtual channel.
// Ports:
//   clk, reset_n       - clock, asynchronous active-low reset (clears pointers/count)
//   wr_en, wr_data     - push; ignored when full
//   rd_en              - pop; ignored when empty
//   rd_data_c          - current front entry (combinational read of storage)
//   full_c, empty_c    - decoded from the registered count
//   count              - registered occupancy
module noc_vc_fifo
#(
    parameter int unsigned WIDTH = 34,
    parameter int unsigned DEPTH = 4
)
(
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             rd_data_c,
    output logic                         full_c,
    output logic                         empty_c,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic             wr_do;
    logic             rd_do;

    assign full_c    = (count == CNT_W'(DEPTH));
    assign empty_c   = (count == '0);
    assign wr_do     = wr_en && !full_c;
    assign rd_do     = rd_en && !empty_c;
    assign rd_data_c = mem[rd_ptr_q];

    // Storage needs no reset; occupancy is tracked by the count
    always_ff @(posedge clk) begin
        if (wr_do) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count    <= '0;
        end else begin
            if (wr_do) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (rd_do) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count <= count + CNT_W'(wr_do) - CNT_W'(rd_do);
        end
    end

endmodule

// File: rtl/noc_vc_input_unit.sv
// Router input port with per-VC FIFOs, credit return and per-VC packet FSMs.
// Optional feature: define NOC_IU_PKT_STATS_EN to add o_pkt_cnt, a per-VC
// saturating count of forwarded packets (TAIL/SINGLE flits).
// Ports:
//   clk, reset_n                  - clock, asynchronous active-low reset
//   i_flit, i_flit_valid, i_flit_vc - upstream flit and its target VC
//   o_credit                      - one-cycle credit pulse per forwarded flit, per VC
//   o_sw_req                      - per-VC switch request
//   o_route                       - latched output port per VC ([v*PORT_W +: PORT_W])
//   i_sw_grant                    - one-hot grant from the switch allocator
//   o_flit, o_flit_valid          - registered flit towards the crossbar
//   o_err                         - sticky protocol-error flag
//   o_pkt_cnt (optional)          - per-VC packet counters ([v*16 +: 16])
module noc_vc_input_unit
    import noc_pkg::*;
#(
    parameter int unsigned FLIT_W   = 34,
    parameter int unsigned NUM_VC   = 2,
    parameter int unsigned VC_DEPTH = 4,
    parameter int unsigned PORT_W   = 3
)
(
    input  logic                                         clk,
    input  logic                                         reset_n,
    input  logic [FLIT_W-1:0]                            i_flit,
    input  logic                                         i_flit_valid,
    input  logic [((NUM_VC > 1) ? $clog2(NUM_VC) : 1)-1:0] i_flit_vc,
    output logic [NUM_VC-1:0]                            o_credit,
    output logic [NUM_VC-1:0]                            o_sw_req,
    output logic [NUM_VC*PORT_W-1:0]                     o_route,
    input  logic [NUM_VC-1:0]                            i_sw_grant,
    output logic [FLIT_W-1:0]                            o_flit,
    output logic                                         o_flit_valid,
    output logic                                         o_err
`ifdef NOC_IU_PKT_STATS_EN
    ,
    output logic [NUM_VC*16-1:0]                         o_pkt_cnt
`endif
);

    localparam int unsigned VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
    localparam int unsigned CNT_W = $clog2(VC_DEPTH) + 1;

    VC_STATE_e           state_q [NUM_VC];
    VC_STATE_e           state_d [NUM_VC];
    logic [FLIT_W-1:0]   front_c [NUM_VC];
    logic [CNT_W-1:0]    fifo_count [NUM_VC];
    logic [CNT_W-1:0]    count_d [NUM_VC];
    logic [NUM_VC-1:0]   full_c;
    logic [NUM_VC-1:0]   empty_c;
    logic [NUM_VC-1:0]   wr_en;
    logic [NUM_VC-1:0]   wr_accept;
    logic [NUM_VC-1:0]   rd_en;
    logic [NUM_VC-1:0]   discard;
    logic [NUM_VC-1:0]   front_tail;
    logic [NUM_VC-1:0]   sw_req_d;
    logic [NUM_VC-1:0]   gnt_pop_c;
    logic                vc_in_range_c;
    logic                grant_any_c;
    logic                grant_onehot_c;
    logic                grant_ok_c;
    logic                grant_err_c;
    logic                wr_err_c;
    logic                err_set_c;
    logic [FLIT_W-1:0]   fwd_flit_c;

    function automatic FLIT_TYPE_e flit_type(input logic [FLIT_W-1:0] f);
        return FLIT_TYPE_e'(f[FLIT_W-1 -: TYPE_W]);
    endfunction

    // VC index range check only exists when the index field can exceed NUM_VC-1
    if ((1 << VC_W) > NUM_VC) begin : g_vc_chk
        assign vc_in_range_c = (32'(i_flit_vc) < NUM_VC);
    end else begin : g_vc_nochk
        assign vc_in_range_c = 1'b1;
    end

    // Grant is honoured only if one-hot and aimed at a requesting VC
    assign grant_any_c    = |i_sw_grant;
    assign grant_onehot_c = grant_any_c && ((i_sw_grant & (i_sw_grant - NUM_VC'(1))) == '0);
    assign grant_ok_c     = grant_onehot_c && (|(i_sw_grant & o_sw_req));
    assign grant_err_c    = grant_any_c && !grant_ok_c;
    assign gnt_pop_c      = grant_ok_c ? i_sw_grant : '0;

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        noc_vc_fifo #(
            .WIDTH (FLIT_W),
            .DEPTH (VC_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .reset_n   (reset_n),
            .wr_en     (wr_en[v]),
            .wr_data   (i_flit),
            .rd_en     (rd_en[v]),
            .rd_data_c (front_c[v]),
            .full_c    (full_c[v]),
            .empty_c   (empty_c[v]),
            .count     (fifo_count[v])
        );
    end

    // Write steering; full is judged on the registered count
    always_comb begin
        wr_err_c = 1'b0;
        for (int v = 0; v < NUM_VC; v++) begin
            wr_en[v]     = i_flit_valid && vc_in_range_c && (i_flit_vc == VC_W'(v));
            wr_accept[v] = wr_en[v] && !full_c[v];
            wr_err_c     = wr_err_c | (wr_en[v] & full_c[v]);
        end
        if (i_flit_valid && !vc_in_range_c) begin
            wr_err_c = 1'b1;
        end
    end

    // Per-VC next state, pops and next-cycle request
    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            state_d[v]    = state_q[v];
            discard[v]    = 1'b0;
            front_tail[v] = flit_is_tail(flit_type(front_c[v]));
            case (state_q[v])
                VC_IDLE: begin
                    if (!empty_c[v]) begin
                        if (flit_is_head(flit_type(front_c[v]))) begin
                            state_d[v] = VC_ROUTING;
                        end else begin
                            discard[v] = 1'b1;
                        end
                    end
                end
                VC_ROUTING: begin
                    state_d[v] = VC_REQ;
                end
                VC_REQ: begin
                    if (gnt_pop_c[v] && front_tail[v]) begin
                        state_d[v] = VC_IDLE;
                    end
                end
                default: begin
                    state_d[v] = VC_IDLE;
                end
            endcase
            rd_en[v]    = discard[v] | gnt_pop_c[v];
            count_d[v]  = fifo_count[v] + CNT_W'(wr_accept[v]) - CNT_W'(rd_en[v]);
            // Request registered so it reflects state/occupancy after this edge
            sw_req_d[v] = (state_d[v] == VC_REQ) && (count_d[v] != '0);
        end
    end

    // Crossbar mux over the (at most one) popped VC
    always_comb begin
        fwd_flit_c = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (gnt_pop_c[v]) begin
                fwd_flit_c = fwd_flit_c | front_c[v];
            end
        end
    end

    assign err_set_c = grant_err_c | wr_err_c | (|discard);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int v = 0; v < NUM_VC; v++) begin
                state_q[v] <= VC_IDLE;
            end
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                state_q[v] <= state_d[v];
            end
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_credit     <= '0;
            o_sw_req     <= '0;
            o_route      <= '0;
            o_flit       <= '0;
            o_flit_valid <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (state_q[v] == VC_ROUTING) begin
                    o_route[v*PORT_W +: PORT_W] <= front_c[v][PORT_LSB +: PORT_W];
                end
            end
            o_sw_req     <= sw_req_d;
            o_credit     <= gnt_pop_c;
            o_flit_valid <= |gnt_pop_c;
            if (|gnt_pop_c) begin
                o_flit <= fwd_flit_c;
            end
            o_err <= o_err | err_set_c;
        end
    end

`ifdef NOC_IU_PKT_STATS_EN
    // Saturating per-VC packet counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_pkt_cnt <= '0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (gnt_pop_c[v] && front_tail[v] && (o_pkt_cnt[v*16 +: 16] != 16'hFFFF)) begin
                    o_pkt_cnt[v*16 +: 16] <= o_pkt_cnt[v*16 +: 16] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_noc_vc_input_unit.sv
// Directed self-checking bench for noc_vc_input_unit (NUM_VC=2, VC_DEPTH=4,
// FLIT_W=34, PORT_W=3). Inputs change 1 time unit after the rising edge and
// outputs are sampled there too; credit pulses are tallied on falling edges.
module tb_noc_vc_input_unit;

    localparam int unsigned FLIT_W   = 34;
    localparam int unsigned NUM_VC   = 2;
    localparam int unsigned VC_DEPTH = 4;
    localparam int unsigned PORT_W   = 3;

    logic                       clk = 1'b0;
    logic                       reset_n = 1'b1;
    logic [FLIT_W-1:0]          i_flit = '0;
    logic                       i_flit_valid = 1'b0;
    logic [0:0]                 i_flit_vc = '0;
    logic [NUM_VC-1:0]          o_credit;
    logic [NUM_VC-1:0]          o_sw_req;
    logic [NUM_VC*PORT_W-1:0]   o_route;
    logic [NUM_VC-1:0]          i_sw_grant = '0;
    logic [FLIT_W-1:0]          o_flit;
    logic                       o_flit_valid;
    logic                       o_err;
`ifdef NOC_IU_PKT_STATS_EN
    logic [NUM_VC*16-1:0]       o_pkt_cnt;
`endif

    int total = 0;
    int bad   = 0;
    int cred0 = 0;
    int cred1 = 0;

    noc_vc_input_unit #(
        .FLIT_W   (FLIT_W),
        .NUM_VC   (NUM_VC),
        .VC_DEPTH (VC_DEPTH),
        .PORT_W   (PORT_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_flit       (i_flit),
        .i_flit_valid (i_flit_valid),
        .i_flit_vc    (i_flit_vc),
        .o_credit     (o_credit),
        .o_sw_req     (o_sw_req),
        .o_route      (o_route),
        .i_sw_grant   (i_sw_grant),
        .o_flit       (o_flit),
        .o_flit_valid (o_flit_valid),
        .o_err        (o_err)
`ifdef NOC_IU_PKT_STATS_EN
        ,
        .o_pkt_cnt    (o_pkt_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_credit[0]) cred0 = cred0 + 1;
        if (o_credit[1]) cred1 = cred1 + 1;
    end

    localparam logic [1:0] T_BODY = 2'b00;
    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b10;
    localparam logic [1:0] T_SNGL = 2'b11;

    function automatic logic [FLIT_W-1:0] mk(input logic [1:0] t, input logic [23:0] pl,
                                             input logic [2:0] port);
        return {t, pl, 5'b0, port};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        i_flit_valid = 1'b0;
        i_sw_grant   = '0;
        i_flit_vc    = '0;
        reset_n      = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic write_flit(input logic vc, input logic [FLIT_W-1:0] f);
        i_flit       = f;
        i_flit_vc    = vc;
        i_flit_valid = 1'b1;
        tick();
        i_flit_valid = 1'b0;
    endtask

    task automatic wait_req(input int v, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (o_sw_req[v]) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset;
        logic [FLIT_W-1:0] f;
        bit ok;
        #1 reset_n = 1'b0;
        #2;
        total++;
        if ({o_credit, o_sw_req, o_route, o_flit, o_flit_valid, o_err} !== '0) begin
            bad++; $display("FAIL reset_outputs got sw_req=%b route=%h flit=%h v=%b err=%b want all 0",
                            o_sw_req, o_route, o_flit, o_flit_valid, o_err);
        end
        tick(); tick();
        reset_n = 1'b1;
        tick();
        write_flit(1'b0, mk(T_HEAD, 24'h00AB01, 3'd2));
        wait_req(0, ok);
        total++;
        if (!ok || o_route[2:0] !== 3'd2) begin
            bad++; $display("FAIL reset_pre_req ok=%0d route0=%0d want ok=1 route0=2", ok, o_route[2:0]);
        end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({o_credit, o_sw_req, o_route, o_flit, o_flit_valid, o_err} !== '0) begin
            bad++; $display("FAIL reset_midpkt got sw_req=%b route=%h flit=%h v=%b err=%b want all 0",
                            o_sw_req, o_route, o_flit, o_flit_valid, o_err);
        end
        tick();
        reset_n = 1'b1;
        tick();
        f = mk(T_SNGL, 24'h0000A5, 3'd5);
        write_flit(1'b0, f);
        wait_req(0, ok);
        i_sw_grant = 2'b01;
        tick();
        i_sw_grant = 2'b00;
        total++;
        if (!ok || o_flit_valid !== 1'b1 || o_flit !== f || o_credit !== 2'b01) begin
            bad++; $display("FAIL reset_after_fwd ok=%0d v=%b flit=%h cred=%b want v=1 flit=%h cred=01",
                            ok, o_flit_valid, o_flit, o_credit, f);
        end
    endtask

    task automatic test_single;
        logic [FLIT_W-1:0] f;
        do_reset();
        f = mk(T_SNGL, 24'h123456, 3'd3);
        write_flit(1'b0, f);
        total++;
        if (o_sw_req !== 2'b00) begin
            bad++; $display("FAIL single_c0_req got %b want 00", o_sw_req);
        end
        tick();
        total++;
        if (o_sw_req !== 2'b00 || o_route[2:0] !== 3'd0) begin
            bad++; $display("FAIL single_c1_routing req=%b route0=%0d want 00/0", o_sw_req, o_route[2:0]);
        end
        tick();
        total++;
        if (o_sw_req !== 2'b01 || o_route[2:0] !== 3'd3) begin
            bad++; $display("FAIL single_c2_req req=%b route0=%0d want 01/3", o_sw_req, o_route[2:0]);
        end
        i_sw_grant = 2'b01;
        tick();
        i_sw_grant = 2'b00;
        total++;
        if (o_flit_valid !== 1'b1 || o_flit !== f || o_credit !== 2'b01 || o_sw_req !== 2'b00) begin
            bad++; $display("FAIL single_c3_fwd v=%b flit=%h cred=%b req=%b want 1/%h/01/00",
                            o_flit_valid, o_flit, o_credit, o_sw_req, f);
        end
        tick();
        total++;
        if (o_flit_valid !== 1'b0 || o_credit !== 2'b00 || o_flit !== f || o_err !== 1'b0) begin
            bad++; $display("FAIL single_c4_hold v=%b cred=%b flit=%h err=%b want 0/00/%h/0",
                            o_flit_valid, o_credit, o_flit, o_err, f);
        end
    endtask

    task automatic test_interleave;
        logic [FLIT_W-1:0] exp_f [6];
        logic [1:0]        gnt [6];
        bit ok0, ok1;
        do_reset();
        cred0 = 0; cred1 = 0;
        exp_f[0] = mk(T_HEAD, 24'h000101, 3'd1);
        exp_f[1] = mk(T_HEAD, 24'h000201, 3'd4);
        exp_f[2] = mk(T_BODY, 24'h000102, 3'd7);
        exp_f[3] = mk(T_BODY, 24'h000202, 3'd7);
        exp_f[4] = mk(T_TAIL, 24'h000103, 3'd7);
        exp_f[5] = mk(T_TAIL, 24'h000203, 3'd7);
        for (int k = 0; k < 6; k++) begin
            gnt[k] = (k % 2 == 0) ? 2'b01 : 2'b10;
            write_flit(k % 2 == 1, exp_f[k]);
        end
        wait_req(0, ok0);
        wait_req(1, ok1);
        total++;
        if (!ok0 || !ok1 || o_route !== 6'b100_001) begin
            bad++; $display("FAIL ilv_route ok=%0d%0d route=%b want 100001", ok0, ok1, o_route);
        end
        for (int k = 0; k < 6; k++) begin
            i_sw_grant = gnt[k];
            tick();
            total++;
            if (o_flit_valid !== 1'b1 || o_flit !== exp_f[k]) begin
                bad++; $display("FAIL ilv_flit%0d v=%b flit=%h want 1/%h", k, o_flit_valid, o_flit, exp_f[k]);
            end
        end
        i_sw_grant = 2'b00;
        tick(); tick();
        total++;
        if (cred0 != 3 || cred1 != 3 || o_sw_req !== 2'b00 || o_err !== 1'b0) begin
            bad++; $display("FAIL ilv_credits c0=%0d c1=%0d req=%b err=%b want 3/3/00/0",
                            cred0, cred1, o_sw_req, o_err);
        end
    endtask

    task automatic test_full;
        logic [FLIT_W-1:0] exp_f [4];
        bit ok;
        do_reset();
        cred0 = 0; cred1 = 0;
        exp_f[0] = mk(T_HEAD, 24'h000301, 3'd6);
        exp_f[1] = mk(T_BODY, 24'h000302, 3'd0);
        exp_f[2] = mk(T_BODY, 24'h000303, 3'd0);
        exp_f[3] = mk(T_TAIL, 24'h000304, 3'd0);
        for (int k = 0; k < 4; k++) begin
            write_flit(1'b1, exp_f[k]);
        end
        total++;
        if (o_err !== 1'b0) begin
            bad++; $display("FAIL full_err_before got %b want 0", o_err);
        end
        write_flit(1'b1, mk(T_SNGL, 24'h000305, 3'd2));
        total++;
        if (o_err !== 1'b1) begin
            bad++; $display("FAIL full_err_set got %b want 1", o_err);
        end
        wait_req(1, ok);
        total++;
        if (!ok || o_route[5:3] !== 3'd6) begin
            bad++; $display("FAIL full_route ok=%0d route1=%0d want 1/6", ok, o_route[5:3]);
        end
        for (int k = 0; k < 4; k++) begin
            i_sw_grant = 2'b10;
            tick();
            total++;
            if (o_flit_valid !== 1'b1 || o_flit !== exp_f[k] || o_credit !== 2'b10) begin
                bad++; $display("FAIL full_b2b%0d v=%b flit=%h cred=%b want 1/%h/10",
                                k, o_flit_valid, o_flit, o_credit, exp_f[k]);
            end
        end
        i_sw_grant = 2'b00;
        tick(); tick(); tick();
        total++;
        if (o_sw_req !== 2'b00 || o_flit_valid !== 1'b0 || cred1 != 4 || cred0 != 0 || o_err !== 1'b1) begin
            bad++; $display("FAIL full_drained req=%b v=%b c1=%0d c0=%0d err=%b want 00/0/4/0/1",
                            o_sw_req, o_flit_valid, cred1, cred0, o_err);
        end
    endtask

    task automatic test_bad_grant;
        logic [FLIT_W-1:0] f1;
        bit ok0, ok1;
        do_reset();
        i_sw_grant = 2'b01;
        tick();
        i_sw_grant = 2'b00;
        total++;
        if (o_flit_valid !== 1'b0 || o_credit !== 2'b00 || o_err !== 1'b1) begin
            bad++; $display("FAIL badgnt_idle v=%b cred=%b err=%b want 0/00/1", o_flit_valid, o_credit, o_err);
        end
        do_reset();
        f1 = mk(T_SNGL, 24'h000402, 3'd2);
        write_flit(1'b0, mk(T_SNGL, 24'h000401, 3'd1));
        write_flit(1'b1, f1);
        wait_req(0, ok0);
        wait_req(1, ok1);
        total++;
        if (!ok0 || !ok1 || o_err !== 1'b0) begin
            bad++; $display("FAIL badgnt_setup ok=%0d%0d err=%b want 11/0", ok0, ok1, o_err);
        end
        i_sw_grant = 2'b11;
        tick();
        i_sw_grant = 2'b00;
        total++;
        if (o_flit_valid !== 1'b0 || o_credit !== 2'b00 || o_err !== 1'b1 || o_sw_req !== 2'b11) begin
            bad++; $display("FAIL badgnt_multi v=%b cred=%b err=%b req=%b want 0/00/1/11",
                            o_flit_valid, o_credit, o_err, o_sw_req);
        end
        i_sw_grant = 2'b10;
        tick();
        i_sw_grant = 2'b00;
        total++;
        if (o_flit_valid !== 1'b1 || o_flit !== f1 || o_credit !== 2'b10) begin
            bad++; $display("FAIL badgnt_recover v=%b flit=%h cred=%b want 1/%h/10",
                            o_flit_valid, o_flit, o_credit, f1);
        end
    endtask

    task automatic test_orphan;
        logic [FLIT_W-1:0] f;
        bit ok;
        do_reset();
        cred0 = 0; cred1 = 0;
        write_flit(1'b0, mk(T_BODY, 24'h000501, 3'd4));
        tick(); tick(); tick();
        total++;
        if (o_err !== 1'b1 || o_sw_req !== 2'b00 || cred0 != 0) begin
            bad++; $display("FAIL orphan_discard err=%b req=%b c0=%0d want 1/00/0", o_err, o_sw_req, cred0);
        end
        f = mk(T_SNGL, 24'h000502, 3'd3);
        write_flit(1'b0, f);
        wait_req(0, ok);
        i_sw_grant = 2'b01;
        tick();
        i_sw_grant = 2'b00;
        tick();
        total++;
        if (!ok || o_flit !== f || cred0 != 1) begin
            bad++; $display("FAIL orphan_next ok=%0d flit=%h c0=%0d want 1/%h/1", ok, o_flit, cred0, f);
        end
    endtask

`ifdef NOC_IU_PKT_STATS_EN
    task automatic test_stats;
        bit ok;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            write_flit(1'b1, mk(T_SNGL, 24'(k), 3'd1));
            wait_req(1, ok);
            i_sw_grant = 2'b10;
            tick();
            i_sw_grant = 2'b00;
            tick();
        end
        total++;
        if (o_pkt_cnt !== {16'd3, 16'd0}) begin
            bad++; $display("FAIL stats_cnt got %h want 00030000", o_pkt_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_interleave();
        test_full();
        test_bad_grant();
        test_orphan();
`ifdef NOC_IU_PKT_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
